// File: rtl/aoc_string_pkg.sv
// Shared constants and types for the string-handling blocks: character and
// string vectors, the character index type and the emitter state encoding.
package aoc_string_pkg;

   localparam int STRING_CHARS = 16;
   localparam int CHAR_W       = 8;

   typedef logic [CHAR_W-1:0]               char_t;
   typedef logic [CHAR_W*STRING_CHARS-1:0]  string_t;
   typedef logic [$clog2(STRING_CHARS+1)-1:0] char_index_t;

   localparam char_t NULL_CHAR = 8'h00;
   localparam char_t LF_CHAR   = 8'h0A;

   typedef enum logic [2:0] {
      IDLE,
      CHARS,
      NEWLINE,
      EOF_CHAR,
      DONE
   } emitter_state_t;

endpackage

// File: rtl/string_emitter.sv
// Serialises right-justified strings into a byte stream, one LF after each
// string and a NULL after the last. Define STRING_EMITTER_IDLE_GAP_EN for a bubble after every byte.
module string_emitter #(
   parameter int OUTBOUND_DATA_WIDTH = 8,
   parameter int STRING_CHARS        = aoc_string_pkg::STRING_CHARS
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 string_valid,
   output logic                                 string_ready,
   input  logic [8*STRING_CHARS-1:0]            string_data,
   input  logic [$clog2(STRING_CHARS+1)-1:0]    string_length,
   input  logic                                 string_last,
   output logic                                 outbound_valid,
   output logic [OUTBOUND_DATA_WIDTH-1:0]       outbound_data,
   output logic                                 done
);
   import aoc_string_pkg::*;

`ifdef STRING_EMITTER_IDLE_GAP_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif

   localparam char_index_t MAX_LEN = char_index_t'(STRING_CHARS);

   emitter_state_t state;
   string_t        data_q;
   char_index_t    pos_q;
   logic           last_q;

   char_index_t    len_clamped;
   char_index_t    first_pos;
   char_index_t    pos_next;
   char_t          first_char;
   char_t          next_char;
   logic           ready_state;
   logic           accept;

   // pos_q is the byte index of the char on the bus; transmission runs from
   // the top of the right-justified string down to byte 0.
   always_comb begin
      len_clamped = (string_length > MAX_LEN) ? MAX_LEN : string_length;
      first_pos   = len_clamped - 1'b1;
      pos_next    = pos_q - 1'b1;
      first_char  = string_data[first_pos*8 +: 8];
      next_char   = data_q[pos_next*8 +: 8];
   end

   // Back-to-back acceptance during the LF is only offered without the gap.
   always_comb begin
      ready_state = 1'b0;
      if (state == IDLE)
         ready_state = 1'b1;
      else if (state == NEWLINE && !last_q && !GAP_EN)
         ready_state = 1'b1;
   end

   assign string_ready = !reset && ready_state;
   assign accept       = string_valid && string_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         outbound_valid <= 1'b0;
         outbound_data  <= '0;
         done           <= 1'b0;
         data_q         <= '0;
         pos_q          <= '0;
         last_q         <= 1'b0;
      end else if (GAP_EN && outbound_valid) begin
         // Insert the bubble and hold the state so the next byte follows it.
         outbound_valid <= 1'b0;
         outbound_data  <= '0;
      end else begin
         case (state)
            IDLE, NEWLINE: begin
               if (accept) begin
                  data_q         <= string_data;
                  last_q         <= string_last;
                  outbound_valid <= 1'b1;
                  if (len_clamped == '0) begin
                     outbound_data <= OUTBOUND_DATA_WIDTH'(LF_CHAR);
                     state         <= NEWLINE;
                  end else begin
                     outbound_data <= OUTBOUND_DATA_WIDTH'(first_char);
                     pos_q         <= first_pos;
                     state         <= CHARS;
                  end
               end else if (state == NEWLINE && last_q) begin
                  outbound_valid <= 1'b1;
                  outbound_data  <= OUTBOUND_DATA_WIDTH'(NULL_CHAR);
                  state          <= EOF_CHAR;
               end else begin
                  outbound_valid <= 1'b0;
                  outbound_data  <= '0;
                  state          <= IDLE;
               end
            end
            CHARS: begin
               outbound_valid <= 1'b1;
               if (pos_q != '0) begin
                  pos_q         <= pos_next;
                  outbound_data <= OUTBOUND_DATA_WIDTH'(next_char);
               end else begin
                  outbound_data <= OUTBOUND_DATA_WIDTH'(LF_CHAR);
                  state         <= NEWLINE;
               end
            end
            EOF_CHAR: begin
               outbound_valid <= 1'b0;
               outbound_data  <= '0;
               done           <= 1'b1;
               state          <= DONE;
            end
            DONE: begin
               outbound_valid <= 1'b0;
               outbound_data  <= '0;
               done           <= 1'b1;
            end
            default: begin
               outbound_valid <= 1'b0;
               outbound_data  <= '0;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/string_emitter.md
STRING_EMITTER -- requirements
Module: string_emitter

Interface
REQ-001 SHALL have parameter OUTBOUND_DATA_WIDTH, default 8, meaning the byte width of the outbound stream; only 8 is supported.
REQ-002 SHALL have parameter STRING_CHARS, default 16, meaning the maximum characters per string.
REQ-003 SHALL have port clk  input  1  clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port string_valid  input  1  upstream string offered.
REQ-006 SHALL have port string_ready  output  1  emitter accepts a string this cycle.
REQ-007 SHALL have port string_data  input  8*STRING_CHARS  packed chars, right-justified: transmission char k sits at byte index (len-1-k).
REQ-008 SHALL have port string_length  input  $clog2(STRING_CHARS+1)  character count, 0..STRING_CHARS.
REQ-009 SHALL have port string_last  input  1  final string; the EOF marker follows its LF.
REQ-010 SHALL have port outbound_valid  output  1  byte strobe.
REQ-011 SHALL have port outbound_data  output  OUTBOUND_DATA_WIDTH  byte.
REQ-012 SHALL have port done  output  1  EOF marker sent, emitter halted.

Function
REQ-013 SHALL use FSM states IDLE, CHARS, NEWLINE, EOF_CHAR, DONE.
REQ-014 SHALL accept a string on string_valid && string_ready, latching data, length (clamped to STRING_CHARS) and last.
REQ-015 SHALL drive string_ready high in IDLE, and in NEWLINE when the latched last is 0; low in every other state.
REQ-016 SHALL drive the first outbound char on the cycle after acceptance (latency 1), then one char per cycle in order k=0..len-1 (CHARS state).
REQ-017 SHALL emit LF (0x0A) in the cycle after the last char; length 0 goes straight to NEWLINE and emits only LF.
REQ-018 SHALL, from NEWLINE, go to CHARS if a string is accepted there (zero-gap back-to-back), to EOF_CHAR if last=1, else to IDLE.
REQ-019 SHALL emit NULL (0x00) with outbound_valid=1 in EOF_CHAR, then enter DONE.
REQ-020 SHALL, in DONE, hold done=1, string_ready=0 and outbound_valid=0 until reset.
REQ-021 SHALL register outbound_valid and outbound_data; outbound_data is 0x00 whenever outbound_valid=0.
REQ-022 SHALL leave outbound content unchanged by string_valid toggling while string_ready=0; there is no downstream backpressure.
REQ-023 SHALL pass chars through unchanged; embedded LF/NULL bytes in string_data are not filtered.

Reset
REQ-024 SHALL, on reset: state IDLE, string_ready=0 in the reset cycle and 1 after it, outbound_valid=0, outbound_data=0x00, done=0.
REQ-025 SHALL, on reset mid-string, abort: no further chars, LF or NULL; outbound_valid=0 from the next cycle.

Configuration
REQ-026 SHALL, when STRING_EMITTER_IDLE_GAP_EN is defined, follow every emitted byte (chars, LF, NULL) with exactly one cycle of outbound_valid=0, and assert string_ready only in IDLE.
REQ-027 SHALL, without STRING_EMITTER_IDLE_GAP_EN, emit bytes on consecutive cycles as per REQ-016..REQ-019.

Structure
REQ-028 SHALL import from the shared package aoc_string_pkg: the STRING_CHARS constant, NULL_CHAR/LF_CHAR constants, and the string_t, char_index_t and char_t typedefs.
REQ-029 SHALL be a single module with the FSM and char index counter inline; no sub-module.

Verification
REQ-030 SHALL cover: "ugknbfddgicrmopn" (len 16, last=1) accepted cycle 0 -> bytes u..n on cycles 1..16, LF cycle 17, NULL cycle 18, done=1 from cycle 19; chained string_filter flags it nice.
REQ-031 SHALL cover: "abc" (len 3, last=0) then "xy" (len 2, last=1) offered continuously -> a,b,c,LF,x,y,LF,NULL on 8 consecutive valid cycles, with ready high during the first LF.
REQ-032 SHALL cover: len 0, last=1 -> LF then NULL, then done=1.
REQ-033 SHALL cover: reset asserted on the cycle of char 5 of a 16-char string -> outbound_valid=0 next cycle, no LF/NULL, string_ready=1 the cycle after reset releases.
REQ-034 SHALL cover: with STRING_EMITTER_IDLE_GAP_EN, "ab" (last=1) -> valid pattern 1,0,1,0,1,0,1,0 carrying a,b,LF,NULL.
REQ-035 SHALL cover: string_length=20 -> clamped to 16 chars, then LF.
